// File: rtl/ws2812_frame_sched.sv
// Frame scheduler for a WS2812 LED chain: streams a buffered frame of GRB words
// to the bit encoder, waits for it to drain, then holds the latch gap.
module ws2812_frame_sched #(
    parameter int NUM_LEDS   = 8,
    parameter int ADDR_W     = 3,
    parameter int RST_CYCLES = 15000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    input  logic              auto_en,
    output logic              px_valid,
    output logic [23:0]       px_data,
    input  logic              px_ready,
    input  logic              enc_busy,
    output logic [ADDR_W-1:0] led_index,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        DRAIN,
        LATCH,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [23:0]       buffer [NUM_LEDS];
    logic [23:0]       rd_word;
    logic [15:0]       gap_cnt;
    logic              start_q;
    logic              valid_q;
    logic              last_px;

    logic              start_d;
    logic              valid_d;
    logic [23:0]       data_d;
    logic [ADDR_W-1:0] index_d;
    logic [15:0]       gap_d;
    logic              busy_d;
    logic              done_d;

    assign last_px  = (led_index == ADDR_W'(NUM_LEDS - 1));
    assign px_valid = valid_q & rst;

    // Out-of-range indices simply match no entry, so such writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                buffer[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (32'(wr_addr) == 32'(i)) begin
                    buffer[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (32'(led_index) == 32'(i)) begin
                rd_word = buffer[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_q) next_state = LOAD;
            LOAD:    next_state = SEND;
            SEND:    if (px_ready) next_state = last_px ? DRAIN : LOAD;
            DRAIN:   if (!enc_busy) next_state = LATCH;
            LATCH:   if (gap_cnt == 16'd0) next_state = DONE;
            DONE:    next_state = auto_en ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Start is registered only while idle, which costs one cycle but makes
    // requests during a frame vanish instead of queuing.
    always_comb begin
        start_d = start && (state == IDLE);
        valid_d = (next_state == SEND);
        data_d  = (state == LOAD) ? rd_word : px_data;
        index_d = led_index;
        if (next_state == LOAD) begin
            index_d = (state == SEND) ? led_index + ADDR_W'(1) : '0;
        end
        gap_d = gap_cnt;
        if (state == DRAIN && next_state == LATCH) begin
            gap_d = 16'(RST_CYCLES - 1);
        end else if (state == LATCH && gap_cnt != 16'd0) begin
            gap_d = gap_cnt - 16'd1;
        end
        busy_d = (next_state != IDLE) || start_d;
        done_d = (next_state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            px_data    <= '0;
            led_index  <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start_q    <= start_d;
            valid_q    <= valid_d;
            px_data    <= data_d;
            led_index  <= index_d;
            gap_cnt    <= gap_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched: eight-LED chain with a 20-cycle latch gap,
// checking word order, stalls, drain, auto-repeat, bad writes and mid-frame reset.
module tb_ws2812_frame_sched;

    localparam int NUM_LEDS   = 8;
    localparam int ADDR_W     = 4;
    localparam int RST_CYCLES = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              start;
    logic              auto_en;
    logic              px_valid;
    logic [23:0]       px_data;
    logic              px_ready;
    logic              enc_busy;
    logic [ADDR_W-1:0] led_index;
    logic              busy;
    logic              frame_done;

    logic [23:0] got[$];
    int          done_cyc[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          stable_err = 0;
    logic        hold_pending = 1'b0;
    logic [23:0] held_data = '0;
    bit          stall_mode = 1'b0;
    int          stall_left = 0;
    int          checks_passed = 0;
    int          checks_total = 0;

    ws2812_frame_sched #(
        .NUM_LEDS  (NUM_LEDS),
        .ADDR_W    (ADDR_W),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .auto_en   (auto_en),
        .px_valid  (px_valid),
        .px_data   (px_data),
        .px_ready  (px_ready),
        .enc_busy  (enc_busy),
        .led_index (led_index),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Edge monitor: records accepted words, frame_done pulses, and any offer
    // that changed or vanished while it was still waiting for px_ready.
    always @(posedge clk) begin
        cyc++;
        if (rst && px_valid && px_ready) got.push_back(px_data);
        if (rst && frame_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (rst && hold_pending && (px_valid !== 1'b1 || px_data !== held_data)) stable_err++;
        hold_pending = rst && px_valid && !px_ready;
        held_data    = px_data;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic tick();
        int n0;
        n0 = got.size();
        @(posedge clk);
        #1;
        if (stall_mode) begin
            if (got.size() != n0) stall_left = $urandom_range(0, 5);
            if (stall_left > 0) begin
                px_ready = 1'b0;
                stall_left--;
            end else begin
                px_ready = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [23:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int waited);
        waited = 0;
        while (frame_done !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        if (frame_done !== 1'b1) checkOutput({tag, "_timeout"}, 32'(frame_done), 32'd1);
    endtask

    task automatic check_ramp(input string tag, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i), 32'(got[first + i]), 32'(i + 1));
        end
    endtask

    initial begin
        int w;
        int n;
        int d0;
        bit wrote;

        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        auto_en  = 1'b0;
        px_ready = 1'b1;
        enc_busy = 1'b0;
        #12;
        checkOutput("rst_px_valid", 32'(px_valid), 32'd0);
        checkOutput("rst_px_data", 32'(px_data), 32'd0);
        checkOutput("rst_led_index", 32'(led_index), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        for (int i = 0; i < NUM_LEDS; i++) applyStimulus(ADDR_W'(i), 24'(i + 1));

        // Nominal frame: start sampled, LOAD, then first offer two edges later.
        got.delete();
        d0 = done_cnt;
        pulse_start();
        checkOutput("t1_busy_rise", 32'(busy), 32'd1);
        checkOutput("t1_valid_k", 32'(px_valid), 32'd0);
        tick();
        checkOutput("t1_valid_k1", 32'(px_valid), 32'd0);
        tick();
        checkOutput("t1_valid_k2", 32'(px_valid), 32'd1);
        checkOutput("t1_first_data", 32'(px_data), 32'h000001);
        wait_done("t1", 200, w);
        checkOutput("t1_done_latency", 32'(w + 2), 32'd38);
        tick();
        checkOutput("t1_busy_fall", 32'(busy), 32'd0);
        checkOutput("t1_done_pulse", 32'(frame_done), 32'd0);
        checkOutput("t1_done_count", 32'(done_cnt - d0), 32'd1);
        checkOutput("t1_words", 32'(got.size()), 32'd8);
        check_ramp("t1", 0, 8);

        // Random px_ready stalls.
        got.delete();
        d0         = done_cnt;
        stall_mode = 1'b1;
        stall_left = 3;
        pulse_start();
        wait_done("t2", 600, w);
        stall_mode = 1'b0;
        px_ready   = 1'b1;
        tick();
        checkOutput("t2_words", 32'(got.size()), 32'd8);
        check_ramp("t2", 0, 8);
        checkOutput("t2_data_stable", 32'(stable_err), 32'd0);
        checkOutput("t2_done_count", 32'(done_cnt - d0), 32'd1);

        // Encoder still shifting after the last word.
        got.delete();
        d0       = done_cnt;
        enc_busy = 1'b1;
        pulse_start();
        n = 0;
        while (got.size() < 8 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("t3_words", 32'(got.size()), 32'd8);
        repeat (50) tick();
        checkOutput("t3_no_early_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("t3_busy_held", 32'(busy), 32'd1);
        enc_busy = 1'b0;
        wait_done("t3", 100, w);
        checkOutput("t3_gap_after_fall", 32'(w), 32'(RST_CYCLES + 1));
        tick();

        // Auto-repeat over three frames with an index-0 rewrite in frame 2.
        got.delete();
        done_cyc.delete();
        d0      = done_cnt;
        wrote   = 1'b0;
        auto_en = 1'b1;
        pulse_start();
        n = 0;
        while (done_cnt - d0 < 3 && n < 400) begin
            if (!wrote && done_cnt - d0 == 1 && px_valid && led_index == 4) begin
                wrote = 1'b1;
                applyStimulus('0, 24'hFF0000);
            end else begin
                if (done_cnt - d0 == 2 && led_index == 2) auto_en = 1'b0;
                tick();
            end
            n++;
        end
        checkOutput("t4_frames", 32'(done_cnt - d0), 32'd3);
        checkOutput("t4_idle_after", 32'(busy), 32'd0);
        checkOutput("t4_words", 32'(got.size()), 32'd24);
        check_ramp("t4_f1", 0, 8);
        checkOutput("t4_f2_old_word0", 32'(got[8]), 32'h000001);
        checkOutput("t4_f2_word4", 32'(got[12]), 32'h000005);
        checkOutput("t4_f3_new_word0", 32'(got[16]), 32'hFF0000);
        checkOutput("t4_f3_word7", 32'(got[23]), 32'h000008);
        checkOutput("t4_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'd38);
        checkOutput("t4_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'd38);
        applyStimulus('0, 24'h000001);

        // Out-of-range write and a start request in the middle of a frame.
        applyStimulus(ADDR_W'(NUM_LEDS), 24'hABCDEF);
        got.delete();
        d0 = done_cnt;
        pulse_start();
        repeat (9) tick();
        pulse_start();
        wait_done("t5", 200, w);
        repeat (40) tick();
        checkOutput("t5_one_frame", 32'(done_cnt - d0), 32'd1);
        checkOutput("t5_idle", 32'(busy), 32'd0);
        checkOutput("t5_words", 32'(got.size()), 32'd8);
        check_ramp("t5", 0, 8);

        // Reset while index 3 is on offer.
        pulse_start();
        n = 0;
        while (!(px_valid && led_index == 3) && n < 50) begin
            tick();
            n++;
        end
        checkOutput("t6_reached_idx3", 32'(px_valid && led_index == 3), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("t6_px_valid", 32'(px_valid), 32'd0);
        checkOutput("t6_px_data", 32'(px_data), 32'd0);
        checkOutput("t6_led_index", 32'(led_index), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_frame_done", 32'(frame_done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        got.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done("t6", 200, w);
        tick();
        checkOutput("t6_words", 32'(got.size()), 32'd8);
        checkOutput("t6_word0_cleared", 32'(got[0]), 32'd0);
        checkOutput("t6_word7_cleared", 32'(got[7]), 32'd0);
        checkOutput("t6_done_count", 32'(done_cnt - d0), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
